// File: rtl/write_back_pkg.sv
// Package: write_back_pkg
// Shared definitions for the write-back stage:
//  - load-size encodings (LS_BYTE / LS_HALF / LS_WORD)
//  - bit positions inside the writeBack control bus (WB_REGWRITE / WB_MEMTOREG)
//  - ZERO_REG, the hard-wired $zero register index
//  - get_byte(): big-endian byte-lane select from a 32-bit word
package write_back_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int ZERO_REG = 0;

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] off);
    logic [7:0] lane;
    case (off)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      2'd3:    lane = word[7:0];
      default: lane = word[7:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/write_back_load_align.sv
// Module: write_back_load_align
// Pure combinational load-data alignment: picks the byte/half/word lane of the
// memory word addressed by the byte offset (big-endian) and sign- or
// zero-extends it to the datapath width.
// Ports:
//  - read_data      in   len  word read from data memory (latched)
//  - offset         in   2    byte offset, low two bits of the effective address
//  - load_size      in   2    LS_BYTE / LS_HALF / LS_WORD (2'b11 behaves as word)
//  - load_unsigned  in   1    1 = zero-extend, 0 = sign-extend
//  - load_data      out  len  aligned, extended load value
module write_back_load_align
  import write_back_pkg::*;
#(
  parameter int len = 32
) (
  input  logic [len-1:0] read_data,
  input  logic [1:0]     offset,
  input  logic [1:0]     load_size,
  input  logic           load_unsigned,
  output logic [len-1:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_fill;
  logic        half_fill;

  // Lane select and extension.
  always_comb begin
    byte_lane = get_byte(read_data[31:0], offset);
    // A misaligned half uses only offset bit 1; bit 0 is ignored silently.
    if (offset[1]) begin
      half_lane = read_data[15:0];
    end else begin
      half_lane = read_data[31:16];
    end
    byte_fill = ~load_unsigned & byte_lane[7];
    half_fill = ~load_unsigned & half_lane[15];
    case (load_size)
      LS_BYTE: load_data = {{(len-8){byte_fill}}, byte_lane};
      LS_HALF: load_data = {{(len-16){half_fill}}, half_lane};
      LS_WORD: load_data = read_data;
      default: load_data = read_data;
    endcase
  end

endmodule

// File: rtl/write_back.sv
// Module: write_back
// Final (WB) stage of the MIPS pipeline: MEM/WB pipeline register followed by
// the write-back select (ALU result or aligned load data). Outputs depend only
// on the latch, so there is no combinational path from any in_* to an output.
// Optional feature macro: WB_RETIRE_COUNT_EN adds out_retired, a wrapping count
// of cycles in which the WB slot held a live instruction.
// Ports:
//  - clk                in   1    clock, posedge
//  - reset              in   1    asynchronous active-low reset
//  - in_valid           in   1    MEM stage presents a real instruction
//  - flush              in   1    kill the instruction being captured
//  - in_writeBack_bus   in   2    [1]=RegWrite, [0]=MemtoReg
//  - in_alu_result      in   len  ALU result / effective address
//  - in_read_data       in   len  data-memory read word
//  - in_write_register  in   NB   destination register index
//  - in_load_size       in   2    00 byte, 01 half, 10/11 word
//  - in_load_unsigned   in   1    1 = zero-extend sub-word load
//  - RegWrite           out  1    register-file write enable
//  - write_data         out  len  register-file write data
//  - write_register     out  NB   register-file write index
//  - out_valid          out  1    WB slot holds a live instruction
//  - out_retired        out  len  retire counter (WB_RETIRE_COUNT_EN only)
module write_back
  import write_back_pkg::*;
#(
  parameter int len = 32,
  parameter int NB  = $clog2(len)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           flush,
  input  logic [1:0]     in_writeBack_bus,
  input  logic [len-1:0] in_alu_result,
  input  logic [len-1:0] in_read_data,
  input  logic [NB-1:0]  in_write_register,
  input  logic [1:0]     in_load_size,
  input  logic           in_load_unsigned,
  output logic           RegWrite,
  output logic [len-1:0] write_data,
  output logic [NB-1:0]  write_register,
  output logic           out_valid
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [len-1:0] out_retired
`endif
);

  logic           valid_q;
  logic [1:0]     wb_q;
  logic [len-1:0] alu_q;
  logic [len-1:0] rdata_q;
  logic [NB-1:0]  reg_q;
  logic [1:0]     ls_q;
  logic           lu_q;
  logic [len-1:0] load_data;

  // MEM/WB pipeline latch; flush turns the captured slot into a bubble but the
  // data fields still load since nothing downstream looks at them then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      wb_q    <= 2'b00;
      alu_q   <= '0;
      rdata_q <= '0;
      reg_q   <= '0;
      ls_q    <= 2'b00;
      lu_q    <= 1'b0;
    end else begin
      valid_q <= in_valid & ~flush;
      wb_q    <= in_writeBack_bus;
      alu_q   <= in_alu_result;
      rdata_q <= in_read_data;
      reg_q   <= in_write_register;
      ls_q    <= in_load_size;
      lu_q    <= in_load_unsigned;
    end
  end

  write_back_load_align #(
    .len(len)
  ) u_load_align (
    .read_data    (rdata_q),
    .offset       (alu_q[1:0]),
    .load_size    (ls_q),
    .load_unsigned(lu_q),
    .load_data    (load_data)
  );

  // Write-back select and register-file write port.
  always_comb begin
    if (wb_q[WB_MEMTOREG]) begin
      write_data = load_data;
    end else begin
      write_data = alu_q;
    end
    // Writes to $zero are dropped here so the register file never sees them.
    RegWrite       = valid_q & wb_q[WB_REGWRITE] & (reg_q != NB'(ZERO_REG));
    write_register = reg_q;
    out_valid      = valid_q;
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [len-1:0] retired_q;

  // Retire counter: counts every live WB slot, including non-writing ones; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_q + {{(len-1){1'b0}}, valid_q};
    end
  end

  assign out_retired = retired_q;
`endif

endmodule
